serial_sub: RTL

Bit-serial unsigned subtractor that computes DIFF = A − B over WIDTH clock cycles, LSB first. Each cycle it presents one operand bit pair plus the registered borrow to a single instance of the existing 1-bit full-subtractor cell `fsub` (ports A, B, C = borrow-in; SUM, BORROW). It captures that cell's SUM/BORROW outputs, making this the sequential stage that feeds and consumes `fsub`. It trades area for latency in the datapath's multi-bit subtract.

---
 rtl/serial_sub_if.sv | 12 +
 rtl/serial_sub.sv | 82 ++++++++
 2 files changed

// File: rtl/serial_sub_if.sv
// serial_sub_if: operand/result bundle between a requester and the bit-serial subtractor
interface serial_sub_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, one bit per cycle LSB first through a single fsub cell
module fsub (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic SUM,
    output logic BORROW
);
    assign SUM = A ^ B ^ C;
    assign BORROW = (~A & B) | (~A & C) | (B & C);
endmodule

module serial_sub #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nx;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             borrow_q;
    logic             d;
    logic             bo;
    logic             last;
    logic             accept;
    fsub u_fsub (.A(sa[0]), .B(sb[0]), .C(br), .SUM(d), .BORROW(bo));
    assign last = cnt == CW'(WIDTH - 1);
    assign accept = bus.start && state != SHIFT;
    assign sr_nx = {d, sr[WIDTH-1:1]};
    assign bus.busy = state == SHIFT;
    assign bus.done = state == FIN;
    assign bus.diff = diff_q;
    assign bus.borrow = borrow_q;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    // next state: IDLE and FIN both accept a new request, SHIFT runs until the last bit
    always_comb begin
        nxt = state;
        nxt = (state == SHIFT) ? (last ? FIN : SHIFT) : (bus.start ? SHIFT : IDLE);
    end
    // datapath: capture operands, shift one bit pair per cycle, publish result on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sa <= '0;
            sb <= '0;
            sr <= '0;
            br <= 1'b0;
            cnt <= '0;
            diff_q <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            sa <= bus.a;
            sb <= bus.b;
            sr <= '0;
            br <= 1'b0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            sr <= sr_nx;
            br <= bo;
            cnt <= last ? cnt : cnt + CW'(1);
            if (last) begin
                diff_q <= sr_nx;
                borrow_q <= bo;
            end
        end
    end
endmodule
